xspi_phy_slave_sync: RTL and testbench
======================================

# xspi_phy_slave_sync

Single-clock successor to the sck-clocked xSPI slave PHY. It runs entirely on the system clock: it oversamples and synchronises `sck_i`, `sce_i` and `sio_i`, then shifts data on detected sck edges. Transactions are loaded through a valid/ready handshake, with programmable dummy cycles, underrun/error flagging and optional DDR. It sits between the pad-level `xspi_phy_io` and the command/flash-emulation logic.

## Interface
- `WORD_SIZE`, 32: width of the transaction data registers, in bits.
- `CYCLE_COUNT_BITS`, 6: width of the bus-cycle and dummy counters.
- `SYNC_STAGES`, 2: flip-flop stages in each input synchroniser (≥2).
- `clk_i`  in  1  system clock. One clock domain only.
- `rst_ni`  in  1  reset. Synchronous, active-low.
- `sck_i`  in  1  SPI clock, asynchronous. CPOL = CPHA.
- `sce_i`  in  1  chip select, active-high (already polarity-corrected by `xspi_phy_io`), asynchronous.
- `sio_i`  in  8  SPI data in, asynchronous.
- `sio_o`  out  8  SPI data out. Unused lanes are 0.
- `sio_oe_o`  out  1  output enable: 1 = drive.
- `txn_valid_i`  in  1  transaction descriptor valid.
- `txn_ready_o`  out  1  block can accept a descriptor.
- `txnbc_i`  in  $clog2(WORD_SIZE)+1  bit count. Legal range 1..WORD_SIZE.
- `txnmode_i`  in  2  lane mode: 00 = 1 lane, 01 = 2, 10 = 4, 11 = 8.
- `txndir_i`  in  1  direction: 0 = receive, 1 = transmit.
- `txndummy_i`  in  CYCLE_COUNT_BITS  dummy cycles to run before data.
- `txndata_i`  in  WORD_SIZE  data to transmit.
- `rxdata_o`  out  WORD_SIZE  received word.
- `rxvalid_o`  out  1  one-clk pulse when a transaction completes.
- `txnerr_o`  out  1  sticky error flag.
- `active_o`  out  1  synchronised sce is high.

## Operation
- **Synchroniser:** `sck_i`, `sce_i` and `sio_i` each pass through SYNC_STAGES flip-flops. A further register on sck and sce provides rise/fall detection (`sck_r`, `sck_f`, `sce_r`, `sce_f`).
- **Bus cycles:** cycles = ceil(bc / 2^mode).
- **State machine:** IDLE, WAIT, DUMMY, XFER.
- **IDLE:**
  - On `sce_r`: go to WAIT and clear `txnerr_o`.
  - `sck` edges are ignored.
- **WAIT:**
  - `txn_ready_o` = 1.
  - On `txn_valid_i & txn_ready_o`, all descriptor fields are latched into shadow registers and the rx shift register and cycle counter are cleared.
  - After latching: go to DUMMY if dummy ≠ 0, else XFER.
  - If bc = 0 or bc > WORD_SIZE: the descriptor is consumed, `txnerr_o` is set, and the state stays WAIT.
  - An `sck_f` or `sck_r` while in WAIT sets `txnerr_o` (underrun). The edge is dropped.
- **DUMMY:**
  - Each `sck_r` increments the dummy counter. Reaching the dummy count moves to XFER.
  - `sio_oe_o` = 0.
- **XFER:**
  - `sio_oe_o` = shadow dir.
  - Output index idx starts at cycles−1 on entry.
  - `sio_o` = `shadow_data[lanes*idx +: lanes]`, zero-extended, so the first transmitted word is the most-significant word (MSW-first).
  - Each `sck_f` after the first `sck_r` of the transaction decrements idx.
  - Each `sck_r` shifts `sio_s[lanes-1:0]` into the LSBs of the rx register and increments the cycle count.
  - On the `sck_r` that completes the last cycle:
    - `rxdata_o` ← the shifted value (LSB-aligned, upper bits zero);
    - `rxvalid_o` pulses;
    - the state goes to WAIT.
- **`sce_f` in any state:** go to IDLE, `sio_oe_o` ← 0, and discard any partial word with no `rxvalid_o`. `txnerr_o` holds its value.
- **Simultaneous events:** `sce_f` has priority over every `sck` edge. A descriptor is accepted only in WAIT.

## Timing
- **Reset values** (`rst_ni` = 0 at a `clk_i` edge): state IDLE, `sio_o` = 0, `sio_oe_o` = 0, `txn_ready_o` = 0, `rxdata_o` = 0, `rxvalid_o` = 0, `txnerr_o` = 0, `active_o` = 0.
- **Edge-detect latency:** SYNC_STAGES+1 clk from a pad edge to the `sck_r`/`sck_f` pulse.
- **`sio_o`/`sio_oe_o` update:** one clk after `sck_f`.
- **`rxvalid_o`:** asserted one clk after the final `sck_r`.
- **Clock-ratio requirement:** f_clk ≥ 8·f_sck (SDR) and ≥ 12·f_sck (DDR).
- **Back-to-back transactions:** the next descriptor must be presented within 2 clk of `rxvalid_o` to avoid an underrun.

## Configuration
- `XSPI_DDR_EN` defined:
  - adds input `txnddr_i` (1 bit), latched with the descriptor;
  - when the latched value is 1, both `sck_r` and `sck_f` count as cycles, both sample `sio_s`, and idx decrements on every edge after the first;
  - dummy cycles still count `sck_r` only.
- `XSPI_DDR_EN` undefined: no `txnddr_i` port; SDR behaviour only.

## Structure
- **Package `xspi_pkg`:**
  - mode constants `XSPI_MODE_1`/`_2`/`_4`/`_8`;
  - state enum;
  - function `xspi_lanes(mode)`;
  - function `xspi_cycles(bc, mode)`.
- **Sub-module `xspi_sync_edge`:** parametrised SYNC_STAGES synchroniser with rise/fall outputs. Instantiated for sck and sce; sio uses a plain synchroniser.

## Test plan
- **Quad receive:** bc = 32, mode 10, dir 0, dummy 0, master sends 0xDEADBEEF → `rxdata_o` = 0xDEADBEEF after 8 `sck` cycles, with one `rxvalid_o` pulse.
- **Single transmit:** bc = 8, mode 00, dir 1, data 0xA5 → `sio_o[0]` sampled at the rises = 1,0,1,0,0,1,0,1; `sio_oe_o` = 1 throughout XFER.
- **Dummy + octal:** dummy 4, bc = 16, mode 11, data 0x1234 → `sio_oe_o` = 0 for 4 rises, then 0x12 then 0x34 on `sio_o`.
- **Odd count:** bc = 5, mode 01 → 3 cycles; the 6 shifted bits appear in `rxdata_o[5:0]`, `[31:6]` = 0.
- **Abort:** `sce_i` falls after 3 of 8 cycles → no `rxvalid_o`, state IDLE, `sio_oe_o` = 0 within SYNC_STAGES+2 clk.
- **Errors:** `sck` toggles with no descriptor loaded → `txnerr_o` = 1 until the next `sce` rise; bc = 0 descriptor → `txnerr_o` = 1 and the block stays in WAIT.

Source files
------------

// File: rtl/xspi_pkg.sv
// Shared types and helpers for the system-clocked xSPI slave PHY.
package xspi_pkg;

  localparam logic [1:0] XSPI_MODE_1 = 2'b00;
  localparam logic [1:0] XSPI_MODE_2 = 2'b01;
  localparam logic [1:0] XSPI_MODE_4 = 2'b10;
  localparam logic [1:0] XSPI_MODE_8 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DUMMY = 2'd2,
    ST_XFER  = 2'd3
  } xspi_state_e;

  function automatic logic [3:0] xspi_lanes(input logic [1:0] mode);
    return 4'd1 << mode;
  endfunction

  // Bus cycles needed for bc bits: ceil(bc / lanes).
  function automatic logic [15:0] xspi_cycles(input logic [15:0] bc, input logic [1:0] mode);
    logic [15:0] lanes_m1;
    lanes_m1 = {12'd0, xspi_lanes(mode)} - 16'd1;
    return (bc + lanes_m1) >> mode;
  endfunction

endpackage

// File: rtl/xspi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous bit, with rise/fall pulses
// derived from one extra register behind the synchronised level.
module xspi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/xspi_phy_slave_sync.sv
// System-clocked xSPI slave PHY: oversampled sck/sce/sio, descriptor-driven
// transfers with dummy cycles. Define XSPI_DDR_EN to add the DDR option.
module xspi_phy_slave_sync
  import xspi_pkg::*;
#(
  parameter  int unsigned WORD_SIZE        = 32,
  parameter  int unsigned CYCLE_COUNT_BITS = 6,
  parameter  int unsigned SYNC_STAGES      = 2,
  localparam int unsigned BCW              = $clog2(WORD_SIZE) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sck_i,
  input  logic                        sce_i,
  input  logic [7:0]                  sio_i,
  output logic [7:0]                  sio_o,
  output logic                        sio_oe_o,
  input  logic                        txn_valid_i,
  output logic                        txn_ready_o,
  input  logic [BCW-1:0]              txnbc_i,
  input  logic [1:0]                  txnmode_i,
  input  logic                        txndir_i,
  input  logic [CYCLE_COUNT_BITS-1:0] txndummy_i,
  input  logic [WORD_SIZE-1:0]        txndata_i,
`ifdef XSPI_DDR_EN
  input  logic                        txnddr_i,
`endif
  output logic [WORD_SIZE-1:0]        rxdata_o,
  output logic                        rxvalid_o,
  output logic                        txnerr_o,
  output logic                        active_o
);

  logic sck_level_unused, sck_r, sck_f;
  logic sce_s, sce_r, sce_f;
  logic [SYNC_STAGES-1:0][7:0] sio_sync_q;
  logic [7:0] sio_s;

  xspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(sck_i),
    .level_o(sck_level_unused), .rise_o(sck_r), .fall_o(sck_f)
  );

  xspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sce_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(sce_i),
    .level_o(sce_s), .rise_o(sce_r), .fall_o(sce_f)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sio_sync_q <= '0;
    else         sio_sync_q <= {sio_sync_q[SYNC_STAGES-2:0], sio_i};
  end
  assign sio_s = sio_sync_q[SYNC_STAGES-1];

  xspi_state_e                 state_q, state_d;
  logic [1:0]                  mode_q, mode_d;
  logic                        dir_q, dir_d;
  logic [CYCLE_COUNT_BITS-1:0] dummy_q, dummy_d;
  logic [CYCLE_COUNT_BITS-1:0] dcnt_q, dcnt_d;
  logic [CYCLE_COUNT_BITS-1:0] cnt_q, cnt_d;
  logic [BCW-1:0]              cycles_q, cycles_d;
  logic [BCW-1:0]              idx_q, idx_d;
  logic                        started_q, started_d;
  logic [WORD_SIZE-1:0]        data_q, data_d;
  logic [WORD_SIZE-1:0]        rx_q, rx_d;
  logic [WORD_SIZE-1:0]        rxdata_q, rxdata_d;
  logic                        rxvalid_q, rxvalid_d;
  logic                        err_q, err_d;
  logic                        ddr;

`ifdef XSPI_DDR_EN
  logic ddr_q, ddr_d;
  assign ddr = ddr_q;
`else
  assign ddr = 1'b0;
`endif

  logic [3:0]           lanes;
  logic [7:0]           lane_mask;
  logic [WORD_SIZE-1:0] rx_shifted;
  logic [WORD_SIZE-1:0] tx_shifted;
  logic [BCW-1:0]       txn_cycles;
  logic                 xfer_edge, idx_edge;

  assign lanes      = xspi_lanes(mode_q);
  assign lane_mask  = 8'hFF >> (4'd8 - lanes);
  assign rx_shifted = (rx_q << lanes) | WORD_SIZE'(sio_s & lane_mask);
  assign tx_shifted = data_q >> (idx_q << mode_q);
  assign txn_cycles = BCW'(xspi_cycles(16'(txnbc_i), txnmode_i));
  // In DDR both sck edges are bus cycles; in SDR only rises sample and falls advance.
  assign xfer_edge  = sck_r | (ddr & sck_f);
  assign idx_edge   = ddr ? (sck_r | sck_f) : sck_f;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    dummy_d   = dummy_q;
    dcnt_d    = dcnt_q;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    idx_d     = idx_q;
    started_d = started_q;
    data_d    = data_q;
    rx_d      = rx_q;
    rxdata_d  = rxdata_q;
    rxvalid_d = 1'b0;
    err_d     = err_q;
`ifdef XSPI_DDR_EN
    ddr_d     = ddr_q;
`endif
    if (sce_f) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sce_r) begin
            state_d = ST_WAIT;
            err_d   = 1'b0;
          end
        end
        ST_WAIT: begin
          if (sck_r | sck_f) err_d = 1'b1;
          if (txn_valid_i) begin
            if (txnbc_i == '0 || txnbc_i > BCW'(WORD_SIZE)) begin
              err_d = 1'b1;
            end else begin
              mode_d    = txnmode_i;
              dir_d     = txndir_i;
              dummy_d   = txndummy_i;
              data_d    = txndata_i;
              cycles_d  = txn_cycles;
              idx_d     = txn_cycles - BCW'(1);
              rx_d      = '0;
              cnt_d     = '0;
              dcnt_d    = '0;
              started_d = 1'b0;
`ifdef XSPI_DDR_EN
              ddr_d     = txnddr_i;
`endif
              state_d   = (txndummy_i != '0) ? ST_DUMMY : ST_XFER;
            end
          end
        end
        ST_DUMMY: begin
          if (sck_r) begin
            dcnt_d = dcnt_q + CYCLE_COUNT_BITS'(1);
            if (dcnt_d == dummy_q) state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          if (idx_edge && started_q && idx_q != '0) idx_d = idx_q - BCW'(1);
          if (xfer_edge) begin
            started_d = 1'b1;
            rx_d      = rx_shifted;
            cnt_d     = cnt_q + CYCLE_COUNT_BITS'(1);
            if (cnt_d == CYCLE_COUNT_BITS'(cycles_q)) begin
              rxdata_d  = rx_shifted;
              rxvalid_d = 1'b1;
              state_d   = ST_WAIT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      mode_q    <= XSPI_MODE_1;
      dir_q     <= 1'b0;
      dummy_q   <= '0;
      dcnt_q    <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
      data_q    <= '0;
      rx_q      <= '0;
      rxdata_q  <= '0;
      rxvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      dummy_q   <= dummy_d;
      dcnt_q    <= dcnt_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      data_q    <= data_d;
      rx_q      <= rx_d;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      err_q     <= err_d;
    end
  end

`ifdef XSPI_DDR_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ddr_q <= 1'b0;
    else         ddr_q <= ddr_d;
  end
`endif

  assign txn_ready_o = (state_q == ST_WAIT);
  assign sio_oe_o    = (state_q == ST_XFER) & dir_q;
  assign sio_o       = (state_q == ST_XFER) ? (tx_shifted[7:0] & lane_mask) : 8'h00;
  assign rxdata_o    = rxdata_q;
  assign rxvalid_o   = rxvalid_q;
  assign txnerr_o    = err_q;
  assign active_o    = sce_s;

endmodule

// File: tb/tb_xspi_phy_slave_sync.sv
// Directed bench for xspi_phy_slave_sync acting as an SPI mode-0 master.
module tb_xspi_phy_slave_sync;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sck_i = 1'b0;
  logic        sce_i = 1'b0;
  logic [7:0]  sio_i = 8'h00;
  logic [7:0]  sio_o;
  logic        sio_oe_o;
  logic        txn_valid_i = 1'b0;
  logic        txn_ready_o;
  logic [5:0]  txnbc_i = 6'd0;
  logic [1:0]  txnmode_i = 2'b00;
  logic        txndir_i = 1'b0;
  logic [5:0]  txndummy_i = 6'd0;
  logic [31:0] txndata_i = 32'h0;
  logic [31:0] rxdata_o;
  logic        rxvalid_o;
  logic        txnerr_o;
  logic        active_o;

  int checks = 0;
  int failures = 0;
  int rxv_cnt = 0;

  xspi_phy_slave_sync dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sck_i(sck_i), .sce_i(sce_i),
    .sio_i(sio_i), .sio_o(sio_o), .sio_oe_o(sio_oe_o),
    .txn_valid_i(txn_valid_i), .txn_ready_o(txn_ready_o),
    .txnbc_i(txnbc_i), .txnmode_i(txnmode_i), .txndir_i(txndir_i),
    .txndummy_i(txndummy_i), .txndata_i(txndata_i),
`ifdef XSPI_DDR_EN
    .txnddr_i(1'b0),
`endif
    .rxdata_o(rxdata_o), .rxvalid_o(rxvalid_o), .txnerr_o(txnerr_o),
    .active_o(active_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (rst_ni && rxvalid_o) rxv_cnt <= rxv_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic sce_up();
    sce_i = 1'b1;
    wait_clk(6);
  endtask

  task automatic sce_down();
    sce_i = 1'b0;
    wait_clk(6);
    sck_i = 1'b0;
    wait_clk(6);
  endtask

  task automatic load(input logic [5:0] bc, input logic [1:0] mode, input logic dir,
                      input logic [5:0] dummy, input logic [31:0] data);
    int n;
    n = 0;
    txnbc_i = bc; txnmode_i = mode; txndir_i = dir; txndummy_i = dummy; txndata_i = data;
    txn_valid_i = 1'b1;
    while (!txn_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("load_ready", {31'd0, txn_ready_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    txn_valid_i = 1'b0;
  endtask

  // One mode-0 bus cycle: drive data in the low half, sample the slave just before the rise.
  task automatic sck_cycle(input logic [7:0] din, input bit last,
                           output logic [7:0] dout, output logic oe);
    sio_i = din;
    wait_clk(6);
    dout = sio_o;
    oe   = sio_oe_o;
    sck_i = 1'b1;
    wait_clk(6);
    if (!last) sck_i = 1'b0;
  endtask

  initial begin
    logic [7:0]  s;
    logic        oe;
    logic [31:0] w;
    logic [7:0]  a5;
    logic [7:0]  odd_in [3];
    int          base;

    wait_clk(3);
    chk("rst_sio", {24'd0, sio_o}, 32'h0);
    chk("rst_oe", {31'd0, sio_oe_o}, 32'h0);
    chk("rst_ready", {31'd0, txn_ready_o}, 32'h0);
    chk("rst_rxdata", rxdata_o, 32'h0);
    chk("rst_rxvalid", {31'd0, rxvalid_o}, 32'h0);
    chk("rst_err", {31'd0, txnerr_o}, 32'h0);
    chk("rst_active", {31'd0, active_o}, 32'h0);
    rst_ni = 1'b1;
    wait_clk(2);

    // Quad receive of 0xDEADBEEF
    sce_up();
    chk("q_active", {31'd0, active_o}, 32'd1);
    chk("q_ready", {31'd0, txn_ready_o}, 32'd1);
    base = rxv_cnt;
    load(6'd32, 2'b10, 1'b0, 6'd0, 32'h0);
    w = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      sck_cycle({4'h0, w[31-4*i -: 4]}, i == 7, s, oe);
      if (i == 0) chk("q_oe", {31'd0, oe}, 32'd0);
    end
    chk("q_rxdata", rxdata_o, 32'hDEADBEEF);
    chk("q_pulses", rxv_cnt - base, 32'd1);
    chk("q_back_wait", {31'd0, txn_ready_o}, 32'd1);
    sce_down();
    chk("q_err", {31'd0, txnerr_o}, 32'd0);
    chk("q_inactive", {31'd0, active_o}, 32'd0);

    // Single-lane transmit of 0xA5, MSB first
    sce_up();
    load(6'd8, 2'b00, 1'b1, 6'd0, 32'h000000A5);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(8'h00, i == 7, s, oe);
      chk($sformatf("tx_bit%0d", i), {31'd0, s[0]}, {31'd0, a5[7-i]});
      chk($sformatf("tx_oe%0d", i), {31'd0, oe}, 32'd1);
    end
    sce_down();

    // Four dummy cycles then octal transmit of 0x1234
    sce_up();
    load(6'd16, 2'b11, 1'b1, 6'd4, 32'h00001234);
    for (int i = 0; i < 4; i++) begin
      sck_cycle(8'h00, 1'b0, s, oe);
      chk($sformatf("dum_oe%0d", i), {31'd0, oe}, 32'd0);
    end
    sck_cycle(8'h00, 1'b0, s, oe);
    chk("oct_w0", {24'd0, s}, 32'h12);
    chk("oct_oe0", {31'd0, oe}, 32'd1);
    sck_cycle(8'h00, 1'b1, s, oe);
    chk("oct_w1", {24'd0, s}, 32'h34);
    sce_down();

    // Odd count: 5 bits on 2 lanes -> 3 cycles, garbage on unused lanes
    sce_up();
    base = rxv_cnt;
    load(6'd5, 2'b01, 1'b0, 6'd0, 32'h0);
    odd_in[0] = 8'hAE; odd_in[1] = 8'h57; odd_in[2] = 8'h31;
    for (int i = 0; i < 3; i++) sck_cycle(odd_in[i], i == 2, s, oe);
    chk("odd_rxdata", rxdata_o, 32'h0000002D);
    chk("odd_pulses", rxv_cnt - base, 32'd1);
    sce_down();
    chk("odd_err", {31'd0, txnerr_o}, 32'd0);

    // Abort after 3 of 8 cycles
    sce_up();
    base = rxv_cnt;
    load(6'd8, 2'b00, 1'b1, 6'd0, 32'h000000FF);
    for (int i = 0; i < 3; i++) sck_cycle(8'h00, 1'b0, s, oe);
    chk("ab_oe_before", {31'd0, sio_oe_o}, 32'd1);
    sce_i = 1'b0;
    wait_clk(4);
    chk("ab_oe_after", {31'd0, sio_oe_o}, 32'd0);
    chk("ab_idle", {31'd0, txn_ready_o}, 32'd0);
    wait_clk(4);
    chk("ab_no_valid", rxv_cnt - base, 32'd0);
    chk("ab_err", {31'd0, txnerr_o}, 32'd0);

    // Underrun: sck toggles with no descriptor
    sce_up();
    sck_i = 1'b1;
    wait_clk(6);
    sck_i = 1'b0;
    wait_clk(6);
    chk("ur_err", {31'd0, txnerr_o}, 32'd1);
    sce_down();
    chk("ur_err_hold", {31'd0, txnerr_o}, 32'd1);
    sce_up();
    chk("ur_err_clr", {31'd0, txnerr_o}, 32'd0);

    // Illegal bit count of zero
    load(6'd0, 2'b00, 1'b0, 6'd0, 32'h0);
    wait_clk(1);
    chk("bc0_err", {31'd0, txnerr_o}, 32'd1);
    chk("bc0_wait", {31'd0, txn_ready_o}, 32'd1);
    sce_down();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
